// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Frame-level scheduler for the sprite controllers of the ping-pong game.
//   On each accepted frame tick it grants every client in turn (client 0
//   first) with a one-hot go, waits for its go/done handshake and forwards
//   the granted client's pixel stream to the VGA adapter through one
//   register stage.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   enable            : allows a new frame to start (a running frame finishes)
//   frame_tick        : one-cycle new-frame request (one-deep pending)
//   client_done       : per-client done level
//   client_plot/x/y/colour : per-client pixel bus, packed by client index
//   go                : one-hot start request to the granted client
//   vga_x/y/colour/plot : registered pixel bus to the VGA adapter
//   active            : index of the granted client (valid while busy)
//   busy              : a frame is in progress
//   frame_done        : one-cycle pulse after the last client completes
//   timeout_err       : sticky, a client exceeded its grant budget
//   overrun           : sticky, a frame tick was dropped
module draw_scheduler #(
    parameter int NUM_CLIENTS = 3,
    parameter int TIMEOUT     = 1000000,
    parameter int TO_W        = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       frame_tick,
    input  logic [NUM_CLIENTS-1:0]     client_done,
    input  logic [NUM_CLIENTS-1:0]     client_plot,
    input  logic [8*NUM_CLIENTS-1:0]   client_x,
    input  logic [7*NUM_CLIENTS-1:0]   client_y,
    input  logic [3*NUM_CLIENTS-1:0]   client_colour,
    output logic [NUM_CLIENTS-1:0]     go,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [2:0]                 vga_colour,
    output logic                       vga_plot,
    output logic [1:0]                 active,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       timeout_err,
    output logic                       overrun
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, NEXT, FIN} state_t;

    // Last counter value of a grant; reaching it without completion skips the client.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [TO_W-1:0]          cnt_q, cnt_d;
    logic                     pending_q, pending_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     overrun_q, overrun_d;
    logic [NUM_CLIENTS-1:0]   go_q, go_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
    logic [1:0]               active_q, active_d;
    logic [7:0]               vga_x_q, vga_x_d;
    logic [6:0]               vga_y_q, vga_y_d;
    logic [2:0]               vga_colour_q, vga_colour_d;
    logic                     vga_plot_q, vga_plot_d;

    logic                     consume;
    logic                     sel_done;
    logic                     sel_plot;
    logic [7:0]               sel_x;
    logic [6:0]               sel_y;
    logic [2:0]               sel_colour;

    // Fields of the currently granted client.
    always_comb begin
        sel_done   = 1'b0;
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (int'(idx_q) == i) begin
                sel_done   = client_done[i];
                sel_plot   = client_plot[i];
                sel_x      = client_x[8*i +: 8];
                sel_y      = client_y[7*i +: 7];
                sel_colour = client_colour[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;
        consume       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q && enable) begin
                    consume = 1'b1;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Leave once the client drops done (it has left its hold state).
                cnt_d = cnt_q + TO_W'(1);
                if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = NEXT;
                end else if (!sel_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A done arriving on the last budget cycle still counts as completion.
                cnt_d = cnt_q + TO_W'(1);
                if (sel_done) begin
                    state_d = NEXT;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = NEXT;
                end
            end
            NEXT: begin
                if (int'(idx_q) == NUM_CLIENTS - 1) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // One-deep request: a tick landing on the consume cycle re-arms it
        // without counting as a dropped tick.
        pending_d = frame_tick ? 1'b1 : (consume ? 1'b0 : pending_q);
        if (frame_tick && pending_q && !consume) begin
            overrun_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            go_d[i] = (state_d == ISSUE) && (int'(idx_d) == i);
        end
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == FIN);
        active_d     = idx_d;

        // Pixel path: one register stage; plot is squashed outside a grant,
        // coordinates hold their last value.
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (state_q == ISSUE || state_q == WAIT_DONE) begin
            vga_x_d      = sel_x;
            vga_y_d      = sel_y;
            vga_colour_d = sel_colour;
            vga_plot_d   = sel_plot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            go_q          <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            active_q      <= 2'd0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            go_q          <= go_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            active_q      <= active_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_plot_q    <= vga_plot_d;
        end
    end

    assign go          = go_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-level draw scheduler and VGA pixel-bus multiplexer for the ping-pong game. On each frame tick it starts every sprite controller (ball, bottom paddle, top paddle, …) in turn with a `go` request and waits for that controller's `done`. While a controller is active, its pixel stream (writeEn/x/y/colour) is forwarded to the single VGA adapter port. It sits between the per-sprite control/datapath pairs and the VGA adapter, and is the initiator side of their go/done handshake.

## Interface
- `NUM_CLIENTS`, 3: number of sprite controllers; client 0 is served first.
- `TIMEOUT`, 1000000: max cycles a client may take per grant before it is skipped.
- `TO_W`, 20: timeout counter width; must satisfy TIMEOUT < 2^TO_W.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: scheduler runs when 1; when 0, no new frame starts (a frame in progress completes).
- `frame_tick` in 1: one-cycle pulse requesting a new frame.
- `client_done` in NUM_CLIENTS: per-client done level (bit i = client i).
- `client_plot` in NUM_CLIENTS: per-client writeEn.
- `client_x` in 8*NUM_CLIENTS: client i at bits [8i+7:8i].
- `client_y` in 7*NUM_CLIENTS: client i at bits [7i+6:7i].
- `client_colour` in 3*NUM_CLIENTS: client i at bits [3i+2:3i].
- `go` out NUM_CLIENTS: one-hot start request; at most one bit high.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: registered pixel bus to the VGA adapter.
- `active` out 2: index of the granted client; valid while `busy`=1.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last client completes.
- `timeout_err` out 1: sticky; set when any client times out. Cleared only by reset.
- `overrun` out 1: sticky; set when a frame_tick is dropped. Cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, NEXT, FIN.
- **IDLE**
  - If `pending` && `enable`: clear `pending`, set idx=0, go to ISSUE.
- **ISSUE**
  - `go[idx]`=1.
  - Stay until `client_done[idx]`=0. This is the client's acknowledgement: it has left its done/hold state.
  - Then go to WAIT_DONE.
  - A client that is already waiting with done=0 acknowledges in 1 cycle.
- **WAIT_DONE**
  - `go`=0.
  - On `client_done[idx]`=1, go to NEXT.
- **Timeout (ISSUE and WAIT_DONE)**
  - The timeout counter resets to 0 on entry to ISSUE and increments every cycle in ISSUE/WAIT_DONE.
  - When the counter reaches TIMEOUT-1 without completion: set `timeout_err`, drop `go`, go to NEXT.
- **NEXT**
  - If idx == NUM_CLIENTS-1, go to FIN.
  - Otherwise idx+1 and go to ISSUE.
- **FIN**
  - `frame_done`=1 for one cycle, then go to IDLE.
- **Pixel mux (registered)**
  - In ISSUE or WAIT_DONE: vga_* <= client[idx] fields.
  - In all other states: `vga_plot` <= 0; x/y/colour hold their last values.
- **frame_tick handling**
  - `pending` is one-deep.
  - A tick sets `pending`.
  - A tick while `pending` is already 1, or while `busy` with `pending` set, sets `overrun`.
  - A tick in the same cycle that IDLE consumes `pending` re-sets `pending`; this is not an overrun.
- **Gating:** `busy` = (state != IDLE). `active` = idx.
- **Reset:** state IDLE, idx 0, pending 0, counter 0, all outputs 0 (including the sticky flags).
- **Reset mid-frame:** `go` and `vga_plot` drop on the next cycle. No `frame_done`.

## Timing
- IDLE to `go[0]` high: 1 cycle after `pending`=1 is observed with `enable`=1.
- `go` comes from a state decode of a registered state, so it is glitch-free. `go` is high for at least 1 cycle.
- Pixel path latency: exactly 1 cycle from `client_*[idx]` to `vga_*`. The last pixel sampled in WAIT_DONE is still emitted on the cycle after the transition to NEXT.
- Client completion to next client's `go`: 2 cycles (WAIT_DONE → NEXT → ISSUE).
- Last client done to `frame_done`: 2 cycles.
- A timeout fires on the TIMEOUT-th cycle after ISSUE entry. Exactly TIMEOUT cycles of grant are given.
- Simultaneous done and timeout in the same cycle: done wins; `timeout_err` is not set.

## Test plan
- **Normal frame:** reset, then 3 model clients (done low on go, done high 40 cycles later, plot=1 with x=70+i) and one frame_tick. Expect go[0], go[1], go[2] in order, each 1 cycle. vga_x tracks 70, 71, 72 at +1 cycle latency. frame_done pulses once, 2 cycles after client 2 done.
- **Already-done client:** client 1 holds done=1 for 30 cycles after go before dropping. Expect go[1] held all 30 cycles, then WAIT_DONE, with no extra grant.
- **Timeout:** TIMEOUT=50, client 1 never raises done. Expect go[1] to drop after exactly 50 cycles, timeout_err=1, client 2 granted 2 cycles later, and frame_done still pulsed.
- **Tick overrun:** 3 frame_ticks during one busy frame. Expect one extra frame to run afterwards and overrun=1.
- **Enable gating:** enable=0 with a tick. Expect no go and pending kept. enable=1 then starts the frame on the next cycle.
- **Reset mid-frame:** assert reset during client 1 WAIT_DONE. Next cycle: go=0, vga_plot=0, busy=0, flags 0, no frame_done.
